// File: rtl/ifq_pkg.sv
// Shared types and constants for the IF->ID decoupling queue.
package ifq_pkg;

    localparam int IFQ_AW   = 32;
    localparam int IFQ_DW   = 32;
    localparam int IFQ_EXCW = 5;

    // ExcCode value meaning "no exception on this fetch".
    localparam logic [IFQ_EXCW-1:0] EXC_NONE = 5'd0;

    // Instruction word presented to Decode for bubbles and faulting fetches.
    localparam logic [IFQ_DW-1:0] NOP_INSTR = 32'h0;

    // One fetched entry as it travels from IF to ID.
    typedef struct packed {
        logic [IFQ_AW-1:0]   pc;
        logic [IFQ_DW-1:0]   instr;
        logic                bd;
        logic [IFQ_EXCW-1:0] exc;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_store.sv
// Entry storage for the IF->ID queue: DEPTH x W register array with one
// synchronous write port and one asynchronous read port. No reset: the
// pointers and count in the parent decide what is valid.
module ifq_store #(
    parameter int DEPTH = 4,
    parameter int W     = 70
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Asynchronous read of the addressed entry.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue. Holds up to DEPTH fetched entries in order and
// presents the head to Decode; an empty queue presents a nop bubble.
//
// Handshake: an entry moves on a side only in a cycle where both valid and
// ready are high at the rising edge (push = in_valid & in_ready,
// pop = out_valid & out_ready). valid never depends on ready of the same side.
//
// Optional feature: define IFQ_BYPASS_EN to let an empty queue forward the
// incoming entry combinationally to Decode in the same cycle.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int EXCW  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            pc_in,
    input  logic [DW-1:0]            instr_in,
    input  logic                     bd_in,
    input  logic [EXCW-1:0]          exc_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            pc_out,
    output logic [DW-1:0]            instr_out,
    output logic                     bd_out,
    output logic [EXCW-1:0]          exc_out,
    output logic [$clog2(DEPTH):0]   count
);

    import ifq_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW + 1 + EXCW;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          push_store;
    logic          pop_store;
    logic          store_we;
    logic [DW-1:0] instr_in_eff;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    // Faulting fetches carry a nop so Decode can never act on their word.
    always_comb begin
        instr_in_eff = (exc_in != EXCW'(EXC_NONE)) ? DW'(NOP_INSTR) : instr_in;
        wdata        = {pc_in, instr_in_eff, bd_in, exc_in};
    end

    // Handshake decode: full/empty, bypass eligibility, and what reaches storage.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        in_ready  = !full;
`ifdef IFQ_BYPASS_EN
        bypass    = empty && in_valid && !flush;
`else
        bypass    = 1'b0;
`endif
        out_valid = !empty || bypass;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        // A bypassed entry that Decode takes right away is never stored.
        push_store = push && !(bypass && out_ready);
        pop_store  = pop && !empty;
        store_we   = push_store && !flush && !reset;
    end

    // Next-state for pointers and occupancy; flush discards everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_store) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_store) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_store) - CW'(pop_store);
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    ifq_store #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Head mux: stored head, bypassed input, or an all-zero bubble.
    always_comb begin
        pc_out    = '0;
        instr_out = DW'(NOP_INSTR);
        bd_out    = 1'b0;
        exc_out   = EXCW'(EXC_NONE);
        if (!empty) begin
            pc_out    = rdata[EW-1 -: AW];
            instr_out = rdata[EXCW+1 +: DW];
            bd_out    = rdata[EXCW];
            exc_out   = rdata[EXCW-1:0];
        end else if (bypass) begin
            pc_out    = pc_in;
            instr_out = instr_in_eff;
            bd_out    = bd_in;
            exc_out   = exc_in;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for the IF->ID queue: reset, fill/full/drain ordering,
// steady push+pop with pointer wrap, flush, nop substitution and bypass.
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        bd_in = 1'b0;
    logic [4:0]  exc_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        bd_out;
    logic [4:0]  exc_out;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(4), .DW(32), .AW(32), .EXCW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .bd_in     (bd_in),
        .exc_in    (exc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_out    (pc_out),
        .instr_out (instr_out),
        .bd_out    (bd_out),
        .exc_out   (exc_out),
        .count     (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc, input logic [31:0] instr,
                              input logic bd, input logic [4:0] exc);
        in_valid  = 1'b1;
        pc_in     = pc;
        instr_in  = instr;
        bd_in     = bd;
        exc_in    = exc;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        bd_in     = 1'b0;
        exc_in    = '0;
    endtask

    task automatic drive_pop();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out: got %h expected 0", instr_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] fill_instr [4];
        fill_instr[0] = 32'h24010001;
        fill_instr[1] = 32'h24020002;
        fill_instr[2] = 32'h24030003;
        fill_instr[3] = 32'h24040004;
        drive_push(32'h3000, fill_instr[0], 1'b0, 5'd0);
        drive_push(32'h3004, fill_instr[1], 1'b0, 5'd0);
        drive_push(32'h3008, fill_instr[2], 1'b0, 5'd0);
        #1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill3_count: got %0d expected 3", count); end
        checks++; if (pc_out !== 32'h3000) begin errors++; $display("FAIL fill3_pc_out: got %h expected 3000", pc_out); end
        checks++; if (instr_out !== 32'h24010001) begin errors++; $display("FAIL fill3_instr_out: got %h expected 24010001", instr_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill3_in_ready: got %b expected 1", in_ready); end
        drive_push(32'h300c, fill_instr[3], 1'b0, 5'd0);
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        // Push attempt while full must be refused.
        in_valid = 1'b1;
        pc_in    = 32'h3010;
        instr_in = 32'hffffffff;
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_push_count: got %0d expected 4", count); end
        // Drain; the first pop also keeps 0x3010 on offer, which must still be refused.
        for (int i = 0; i < 4; i++) begin
            in_valid = (i == 0);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (pc_out !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, pc_out, 32'h3000 + 32'(4 * i)); end
            checks++; if (instr_out !== fill_instr[i]) begin errors++; $display("FAIL drain_instr[%0d]: got %h expected %h", i, instr_out, fill_instr[i]); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (i == 0) begin
                checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_count: got %0d expected 3", count); end
            end
        end
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drained_valid: got %b expected 0", out_valid); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL drained_instr: got %h expected 0", instr_out); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL drained_pc: got %h expected 0", pc_out); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drained_count: got %0d expected 0", count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] npc;
        exp_q.delete();
        drive_push(32'h4000, {16'h2400, 16'h4000}, 1'b0, 5'd0);
        exp_q.push_back(32'h4000);
        drive_push(32'h4004, {16'h2400, 16'h4004}, 1'b0, 5'd0);
        exp_q.push_back(32'h4004);
        for (int i = 0; i < 10; i++) begin
            npc       = 32'h4008 + 32'(4 * i);
            in_valid  = 1'b1;
            pc_in     = npc;
            instr_in  = {16'h2400, npc[15:0]};
            out_ready = 1'b1;
            #1;
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
            checks++; if (pc_out !== exp_q[0]) begin errors++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, pc_out, exp_q[0]); end
            checks++; if (instr_out !== {16'h2400, exp_q[0][15:0]}) begin errors++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, instr_out, {16'h2400, exp_q[0][15:0]}); end
            exp_q.push_back(npc);
            void'(exp_q.pop_front());
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_end_count: got %0d expected 2", count); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (pc_out !== exp_q[0]) begin errors++; $display("FAIL b2b_drain_pc[%0d]: got %h expected %h", i, pc_out, exp_q[0]); end
            void'(exp_q.pop_front());
            drive_pop();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        drive_push(32'h5000, 32'h24050000, 1'b1, 5'd0);
        drive_push(32'h5004, 32'h24050004, 1'b0, 5'd0);
        drive_push(32'h5008, 32'h24050008, 1'b0, 5'd0);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
        flush    = 1'b1;
        in_valid = 1'b1;
        pc_in    = 32'h5abc;
        instr_in = 32'h11111111;
        bd_in    = 1'b1;
        exc_in   = 5'd3;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        bd_in    = 1'b0;
        exc_in   = 5'd0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL flush_pc: got %h expected 0", pc_out); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL flush_instr: got %h expected 0", instr_out); end
        checks++; if (bd_out !== 1'b0) begin errors++; $display("FAIL flush_bd: got %b expected 0", bd_out); end
        checks++; if (exc_out !== 5'd0) begin errors++; $display("FAIL flush_exc: got %0d expected 0", exc_out); end
        drive_push(32'h6000, 32'h24060006, 1'b0, 5'd0);
        #1;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL post_flush_count: got %0d expected 1", count); end
        checks++; if (pc_out !== 32'h6000) begin errors++; $display("FAIL post_flush_pc: got %h expected 6000", pc_out); end
        drive_pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_flush_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_exc_nop();
        drive_push(32'h7000, 32'h8C010000, 1'b1, 5'd4);
        drive_push(32'h7004, 32'h12345678, 1'b0, 5'd0);
        #1;
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL exc_instr: got %h expected 0", instr_out); end
        checks++; if (exc_out !== 5'd4) begin errors++; $display("FAIL exc_code: got %0d expected 4", exc_out); end
        checks++; if (bd_out !== 1'b1) begin errors++; $display("FAIL exc_bd: got %b expected 1", bd_out); end
        checks++; if (pc_out !== 32'h7000) begin errors++; $display("FAIL exc_pc: got %h expected 7000", pc_out); end
        drive_pop();
        checks++; if (instr_out !== 32'h12345678) begin errors++; $display("FAIL noexc_instr: got %h expected 12345678", instr_out); end
        checks++; if (exc_out !== 5'd0) begin errors++; $display("FAIL noexc_code: got %0d expected 0", exc_out); end
        checks++; if (bd_out !== 1'b0) begin errors++; $display("FAIL noexc_bd: got %b expected 0", bd_out); end
        checks++; if (pc_out !== 32'h7004) begin errors++; $display("FAIL noexc_pc: got %h expected 7004", pc_out); end
        drive_pop();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL exc_end_count: got %0d expected 0", count); end
    endtask

    task automatic test_bypass();
        in_valid  = 1'b1;
        pc_in     = 32'h3020;
        instr_in  = 32'h24200020;
        out_ready = 1'b1;
        #1;
`ifdef IFQ_BYPASS_EN
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b expected 1", out_valid); end
        checks++; if (pc_out !== 32'h3020) begin errors++; $display("FAIL bypass_pc: got %h expected 3020", pc_out); end
        checks++; if (instr_out !== 32'h24200020) begin errors++; $display("FAIL bypass_instr: got %h expected 24200020", instr_out); end
`else
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nobypass_valid: got %b expected 0", out_valid); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL nobypass_pc: got %h expected 0", pc_out); end
`endif
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
`ifdef IFQ_BYPASS_EN
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", count); end
`else
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL nobypass_count: got %0d expected 1", count); end
        checks++; if (pc_out !== 32'h3020) begin errors++; $display("FAIL nobypass_head: got %h expected 3020", pc_out); end
        drive_pop();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL nobypass_end_count: got %0d expected 0", count); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_exc_nop();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
